// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vid_timing_gen
// Purpose  : Programmable raster timing generator with a small write-only
//            register bus. Produces sync/blank timing, a per-line fetch
//            request with its start address, and a frame-start pulse.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            selin, cmdin,
//            addrdatain       - bus request (offset cycle, then data cycle)
//            cmdout           - 3'b101 for one clk as the write response
//            hsync, vsync     - sync outputs, polarity selectable in CR
//            hblank, vblank   - active-high blanking
//            line_req,
//            line_addr        - fetch request and start address of next line
//            frame_start      - one-clk pulse at pixel (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vid_timing_gen #(
    parameter int CNT_W  = 13,
    parameter int PCNT_W = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              selin,
    input  logic [2:0]        cmdin,
    input  logic [31:0]       addrdatain,
    output logic [2:0]        cmdout,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank,
    output logic              vblank,
    output logic              line_req,
    output logic [ADDR_W-1:0] line_addr,
    output logic              frame_start
);

    localparam logic [2:0] c_CMD_WRITE = 3'b100;
    localparam logic [2:0] c_CMD_RESP  = 3'b101;

    // Register selects decoded once, on the request cycle
    localparam logic [2:0] c_SEL_CR   = 3'd0;
    localparam logic [2:0] c_SEL_H1   = 3'd1;
    localparam logic [2:0] c_SEL_H2   = 3'd2;
    localparam logic [2:0] c_SEL_V1   = 3'd3;
    localparam logic [2:0] c_SEL_V2   = 3'd4;
    localparam logic [2:0] c_SEL_BASE = 3'd5;
    localparam logic [2:0] c_SEL_LINC = 3'd6;
    localparam logic [2:0] c_SEL_NONE = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } bus_state_t;

    bus_state_t r_state, w_state_nxt;
    logic [2:0] r_wsel, w_sel_dec;
    logic       w_req, w_wr;

    // ------------------------------------------------------------------ bus
    assign w_req = selin && (cmdin == c_CMD_WRITE);
    assign w_wr  = (r_state == S_DATA);

    always_comb begin
        case (addrdatain)
            32'h0000_0000: w_sel_dec = c_SEL_CR;
            32'h0000_0028: w_sel_dec = c_SEL_H1;
            32'h0000_0030: w_sel_dec = c_SEL_H2;
            32'h0000_0038: w_sel_dec = c_SEL_V1;
            32'h0000_0040: w_sel_dec = c_SEL_V2;
            32'h0000_0048: w_sel_dec = c_SEL_BASE;
            32'h0000_0050: w_sel_dec = c_SEL_LINC;
            default:       w_sel_dec = c_SEL_NONE;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_nxt = S_DATA;
            S_DATA:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wsel  <= c_SEL_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_req)
                r_wsel <= w_sel_dec;
        end
    end

    assign cmdout = (r_state == S_RESP) ? c_CMD_RESP : 3'b000;

    // ------------------------------------------------- programmed registers
    logic              r_en, r_hpol, r_vpol;
    logic [PCNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0]  r_hend, r_hsize, r_hse, r_hss;
    logic [CNT_W-1:0]  r_vend, r_vsize, r_vse, r_vss;
    logic [ADDR_W-1:0] r_base, r_lineinc;
    logic [CNT_W-1:0]  w_lo, w_hi;
    logic              w_unused;

    assign w_lo = addrdatain[CNT_W-1:0];
    assign w_hi = addrdatain[13 +: CNT_W];
    // Only some data bits map to fields; the rest are deliberately dropped
    assign w_unused = &{1'b0, addrdatain, 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en    <= 1'b0;  r_hpol  <= 1'b0;  r_vpol <= 1'b0;  r_pcnt <= '0;
            r_hend  <= '0;    r_hsize <= '0;    r_hse  <= '0;    r_hss  <= '0;
            r_vend  <= '0;    r_vsize <= '0;    r_vse  <= '0;    r_vss  <= '0;
            r_base  <= '0;    r_lineinc <= '0;
        end else if (w_wr) begin
            case (r_wsel)
                c_SEL_CR: begin
                    r_en   <= addrdatain[3];
                    r_pcnt <= addrdatain[4 +: PCNT_W];
                    r_hpol <= addrdatain[10];
                    r_vpol <= addrdatain[11];
                end
                c_SEL_H1:   begin r_hend <= w_lo; r_hsize <= w_hi; end
                c_SEL_H2:   begin r_hse  <= w_lo; r_hss   <= w_hi; end
                c_SEL_V1:   begin r_vend <= w_lo; r_vsize <= w_hi; end
                c_SEL_V2:   begin r_vse  <= w_lo; r_vss   <= w_hi; end
                c_SEL_BASE: r_base    <= addrdatain[ADDR_W-1:0];
                c_SEL_LINC: r_lineinc <= addrdatain[ADDR_W-1:0];
                default:    ;
            endcase
        end
    end

    // ------------------------------------------------------ timing core
    logic [CNT_W-1:0]  r_sh_hend, r_sh_hsize, r_sh_hse, r_sh_hss;
    logic [CNT_W-1:0]  r_sh_vend, r_sh_vsize, r_sh_vse, r_sh_vss;
    logic [ADDR_W-1:0] r_sh_lineinc, r_acc, w_next_addr;
    logic [PCNT_W-1:0] r_div;
    logic [CNT_W-1:0]  r_hcnt, r_vcnt, w_vnext;
    logic              r_tick_q;
    logic              w_tick, w_hwrap, w_vwrap, w_frame_wrap, w_line_req;

    // >= rather than == so a smaller pcnt written mid-count cannot overrun
    assign w_tick       = r_en && (r_div >= r_pcnt);
    assign w_hwrap      = (r_hcnt == r_sh_hend);
    assign w_vwrap      = (r_vcnt == r_sh_vend);
    assign w_frame_wrap = w_tick && w_hwrap && w_vwrap;
    assign w_vnext      = w_vwrap ? '0 : r_vcnt + 1'b1;

    // r_tick_q marks the first clk with freshly advanced counters, so the
    // fetch request lines up with the registered hblank rising edge.
    assign w_line_req  = r_tick_q && (r_hcnt == r_sh_hsize) && (w_vnext < r_sh_vsize);
    // Line 0 of the next frame uses the base that the accumulator will
    // load at the frame wrap.
    assign w_next_addr = w_vwrap ? r_base : r_acc + r_sh_lineinc;

    always_ff @(posedge clk) begin
        if (reset || !r_en) begin
            r_div    <= '0;
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= w_tick;
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_hcnt <= w_hwrap ? '0 : r_hcnt + 1'b1;
                if (w_hwrap)
                    r_vcnt <= w_vnext;
            end
        end
    end

    // While disabled the shadows follow the programmed set, so they hold
    // exactly that set on the first enabled clk. The accumulator doubles
    // as the active copy of base (current line start address).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_hend <= '0;  r_sh_hsize <= '0;  r_sh_hse <= '0;  r_sh_hss <= '0;
            r_sh_vend <= '0;  r_sh_vsize <= '0;  r_sh_vse <= '0;  r_sh_vss <= '0;
            r_sh_lineinc <= '0;
            r_acc        <= '0;
        end else if (!r_en || w_frame_wrap) begin
            r_sh_hend <= r_hend;  r_sh_hsize <= r_hsize;
            r_sh_hse  <= r_hse;   r_sh_hss   <= r_hss;
            r_sh_vend <= r_vend;  r_sh_vsize <= r_vsize;
            r_sh_vse  <= r_vse;   r_sh_vss   <= r_vss;
            r_sh_lineinc <= r_lineinc;
            r_acc        <= r_base;
        end else if (w_tick && w_hwrap) begin
            r_acc <= r_acc + r_sh_lineinc;
        end
    end

    // ------------------------------------------------------ output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            line_req    <= 1'b0;
            frame_start <= 1'b0;
            line_addr   <= '0;
        end else if (!r_en) begin
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= r_hpol;
            vsync       <= r_vpol;
            line_req    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hblank      <= (r_hcnt >= r_sh_hsize);
            vblank      <= (r_vcnt >= r_sh_vsize);
            hsync       <= ((r_hcnt >= r_sh_hss) && (r_hcnt < r_sh_hse)) ^ r_hpol;
            vsync       <= ((r_vcnt >= r_sh_vss) && (r_vcnt < r_sh_vse)) ^ r_vpol;
            line_req    <= w_line_req;
            frame_start <= w_tick && (r_hcnt == '0) && (r_vcnt == '0);
            if (w_line_req)
                line_addr <= w_next_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_timing_gen
// Purpose  : Directed self-checking bench for vid_timing_gen
// Revision : 1.0 - initial release
// ============================================================================
module tb_vid_timing_gen;

    localparam logic [31:0] c_H1     = 32'h0000_E009; // hsize 7, hend 9
    localparam logic [31:0] c_H1_NEW = 32'h0000_E00B; // hsize 7, hend 11
    localparam logic [31:0] c_H2     = 32'h0001_0009; // hsync 8..9
    localparam logic [31:0] c_V1     = 32'h0000_6004; // vsize 3, vend 4
    localparam logic [31:0] c_V2     = 32'h0000_6004; // vsync 3..4

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        selin = 1'b0;
    logic [2:0]  cmdin = 3'b000;
    logic [31:0] addrdatain = 32'h0;
    logic [2:0]  cmdout;
    logic        hsync, vsync, hblank, vblank, line_req, frame_start;
    logic [31:0] line_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vid_timing_gen #(.CNT_W(13), .PCNT_W(6), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin),
        .addrdatain(addrdatain), .cmdout(cmdout), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .line_req(line_req),
        .line_addr(line_addr), .frame_start(frame_start)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Returns on the negedge of the response cycle
    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk); selin = 1'b1; cmdin = 3'b100; addrdatain = off;
        @(negedge clk); cmdin = 3'b000; addrdatain = data;
        @(negedge clk); selin = 1'b0; addrdatain = 32'h0;
    endtask

    task automatic test_reset();
        logic [8:0] g;
        repeat (3) @(negedge clk);
        g = {cmdout, hsync, vsync, hblank, vblank, line_req, frame_start};
        n_cmp++;
        if (g !== 9'b000_0011_00) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", g, 9'b000_0011_00);
        end
        n_cmp++;
        if (line_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_line_addr: got %h expected 0", line_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        g = {cmdout, hsync, vsync, hblank, vblank, line_req, frame_start};
        n_cmp++;
        if (g !== 9'b000_0011_00) begin
            n_err++; $display("FAIL idle_outputs: got %b expected %b", g, 9'b000_0011_00);
        end
    endtask

    task automatic test_bus();
        bus_write(32'h28, c_H1);
        bus_write(32'h30, c_H2);
        bus_write(32'h38, c_V1);
        bus_write(32'h40, c_V2);
        bus_write(32'h48, 32'h0000_1000);
        bus_write(32'h50, 32'h0000_0200);
        bus_write(32'h08, 32'hFFFF_FFFF);        // unmapped offset
        n_cmp++;
        if (cmdout !== 3'b101) begin
            n_err++; $display("FAIL unmapped_resp: got %b expected 101", cmdout);
        end
        @(negedge clk);
        n_cmp++;
        if (cmdout !== 3'b000) begin
            n_err++; $display("FAIL unmapped_resp_end: got %b expected 000", cmdout);
        end
        // Enable write, with extra requests in DATA and RESP that must be ignored
        @(negedge clk); selin = 1'b1; cmdin = 3'b100; addrdatain = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (cmdout !== 3'b000) begin
            n_err++; $display("FAIL resp_early: got %b expected 000", cmdout);
        end
        addrdatain = 32'h0000_0008;
        @(negedge clk);
        n_cmp++;
        if (cmdout !== 3'b101) begin
            n_err++; $display("FAIL resp: got %b expected 101", cmdout);
        end
        n_cmp++;
        if (frame_start !== 1'b0) begin
            n_err++; $display("FAIL fs_early: got %b expected 0", frame_start);
        end
        addrdatain = 32'h0000_0008;
        @(negedge clk);
        selin = 1'b0; cmdin = 3'b000; addrdatain = 32'h0;
        n_cmp++;
        if (cmdout !== 3'b000) begin
            n_err++; $display("FAIL resp_len: got %b expected 000", cmdout);
        end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_err++; $display("FAIL fs_first_tick: got %b expected 1", frame_start);
        end
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (cmdout !== 3'b000) begin
                n_err++; $display("FAIL resp_ignored_req: got %b expected 000", cmdout);
            end
        end
    endtask

    task automatic test_timing();
        int cnt;
        int h, v;
        logic [5:0] e, g;
        logic [31:0] ea;
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_err++; $display("FAIL timing_find_fs: got %b expected 1", frame_start);
        end
        for (int j = 0; j < 100; j++) begin
            h = j % 10;
            v = (j / 10) % 5;
            e = {h >= 7, v >= 3, h == 8, v == 3,
                 (h == 7) && (v == 0 || v == 1 || v == 4), (j % 50) == 0};
            g = {hblank, vblank, hsync, vsync, line_req, frame_start};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL timing j=%0d {hb,vb,hs,vs,lr,fs}: got %b expected %b", j, g, e);
            end
            if (e[1]) begin
                ea = (v == 0) ? 32'h1200 : (v == 1) ? 32'h1400 : 32'h1000;
                n_cmp++;
                if (line_addr !== ea) begin
                    n_err++; $display("FAIL line_addr j=%0d: got %h expected %h", j, line_addr, ea);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shadow();
        int cnt;
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        bus_write(32'h28, c_H1_NEW);
        cnt = 3;
        do begin @(negedge clk); cnt++; end while (frame_start !== 1'b1 && cnt < 400);
        n_cmp++;
        if (cnt != 50) begin
            n_err++; $display("FAIL old_frame_len: got %0d expected 50", cnt);
        end
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (line_req !== 1'b1 && cnt < 400);
        n_cmp++;
        if (cnt != 7) begin
            n_err++; $display("FAIL new_first_req: got %0d expected 7", cnt);
        end
        do begin @(negedge clk); cnt++; end while (line_req !== 1'b1 && cnt < 400);
        n_cmp++;
        if (cnt != 19) begin
            n_err++; $display("FAIL new_line_period: got %0d expected 19", cnt);
        end
        do begin @(negedge clk); cnt++; end while (frame_start !== 1'b1 && cnt < 400);
        n_cmp++;
        if (cnt != 60) begin
            n_err++; $display("FAIL new_frame_len: got %0d expected 60", cnt);
        end
    endtask

    task automatic test_pcnt();
        int cnt;
        logic seen;
        logic [5:0] g;
        bus_write(32'h00, 32'h0);
        @(negedge clk);
        g = {hblank, vblank, hsync, vsync, line_req, frame_start};
        n_cmp++;
        if (g !== 6'b110000) begin
            n_err++; $display("FAIL disabled_outputs: got %b expected 110000", g);
        end
        bus_write(32'h28, c_H1);
        bus_write(32'h00, 32'h0000_0038);          // en, pcnt=3
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (frame_start !== (k == 4)) begin
                n_err++; $display("FAIL pcnt_first_tick k=%0d: got %b expected %b", k, frame_start, k == 4);
            end
        end
        @(negedge clk);
        cnt = 1;
        n_cmp++;
        if (frame_start !== 1'b0) begin
            n_err++; $display("FAIL fs_width: got %b expected 0", frame_start);
        end
        while (hblank !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
        n_cmp++;
        if (cnt != 25) begin
            n_err++; $display("FAIL pcnt_hblank_pos: got %0d expected 25", cnt);
        end
        n_cmp++;
        if (line_req !== 1'b1 || line_addr !== 32'h1200) begin
            n_err++; $display("FAIL pcnt_line_req: got %b/%h expected 1/00001200", line_req, line_addr);
        end
        do begin @(negedge clk); cnt++; end while (frame_start !== 1'b1 && cnt < 400);
        n_cmp++;
        if (cnt != 200) begin
            n_err++; $display("FAIL pcnt_frame_len: got %0d expected 200", cnt);
        end
        // Disable mid-line with hpol set
        repeat (12) @(negedge clk);
        bus_write(32'h00, 32'h0000_0430);
        @(negedge clk);
        g = {hblank, vblank, hsync, vsync, line_req, frame_start};
        n_cmp++;
        if (g !== 6'b111000) begin
            n_err++; $display("FAIL midline_disable: got %b expected 111000", g);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (frame_start === 1'b1 || line_req === 1'b1 || hblank !== 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL disabled_hold: got activity %b expected 0", seen);
        end
        bus_write(32'h00, 32'h0000_0038);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (frame_start !== (k == 4)) begin
                n_err++; $display("FAIL reenable_tick k=%0d: got %b expected %b", k, frame_start, k == 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        logic [8:0] g;
        @(negedge clk); selin = 1'b1; cmdin = 3'b100; addrdatain = 32'h50;
        @(negedge clk); cmdin = 3'b000; addrdatain = 32'h40; reset = 1'b1;
        @(negedge clk); selin = 1'b0; addrdatain = 32'h0;
        g = {cmdout, hsync, vsync, hblank, vblank, line_req, frame_start};
        n_cmp++;
        if (g !== 9'b000_0011_00) begin
            n_err++; $display("FAIL midreset_outputs: got %b expected %b", g, 9'b000_0011_00);
        end
        n_cmp++;
        if (line_addr !== 32'h0) begin
            n_err++; $display("FAIL midreset_line_addr: got %h expected 0", line_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (cmdout !== 3'b000) begin
                n_err++; $display("FAIL midreset_no_resp: got %b expected 000", cmdout);
            end
        end
        bus_write(32'h28, c_H1);
        bus_write(32'h30, c_H2);
        bus_write(32'h38, c_V1);
        bus_write(32'h40, c_V2);
        bus_write(32'h48, 32'h0000_1000);
        bus_write(32'h00, 32'h0000_0008);
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < 10) begin @(negedge clk); cnt++; end
        n_cmp++;
        if (cnt != 1) begin
            n_err++; $display("FAIL midreset_fs: got %0d expected 1", cnt);
        end
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (line_req !== 1'b1 && cnt < 100);
        n_cmp++;
        if (cnt != 7 || line_addr !== 32'h1000) begin
            n_err++; $display("FAIL midreset_lineinc: got %0d/%h expected 7/00001000", cnt, line_addr);
        end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_timing();
        test_shadow();
        test_pcnt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_timing_gen.md
VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 13, meaning width of pixel/line counters and timing fields (legal 8..13).
REQ-002 SHALL have parameter PCNT_W, default 6, meaning width of the pixel-divider field.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning width of base, lineinc and line_addr.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 selin  in  1  bus select; cmdin/addrdatain ignored when 0.
REQ-007 cmdin  in  3  bus command; 3'b100 = write request.
REQ-008 addrdatain  in  32  register offset on request cycle, write data on following cycle.
REQ-009 cmdout  out  3  3'b101 = write response; 3'b000 otherwise.
REQ-010 hsync, vsync  out  1 each  sync outputs, polarity per CR.
REQ-011 hblank, vblank  out  1 each  active-high blanking.
REQ-012 line_req  out  1  one-clk pulse requesting fetch of next displayed line.
REQ-013 line_addr  out  ADDR_W  start address of the requested line, valid with line_req.
REQ-014 frame_start  out  1  one-clk pulse at pixel (0,0).

Function
REQ-015 Bus FSM states IDLE, DATA, RESP: IDLE->DATA on selin&&cmdin==3'b100 (latch offset); DATA->RESP next clk (write data captured); RESP drives cmdout=3'b101 one clk ->IDLE.
REQ-016 Write request arriving in DATA or RESP SHALL be ignored; writes to unmapped offsets SHALL still respond and change nothing.
REQ-017 Register map: 0x00 CR (en=bit3, pcnt=[4+PCNT_W-1:4], hpol=bit10, vpol=bit11); 0x28 H1 (hend low, hsize high); 0x30 H2 (hsync_end low, hsync_start high); 0x38 V1 (vend low, vsize high); 0x40 V2 (vsync_end low, vsync_start high); 0x48 base; 0x50 lineinc.
REQ-018 Low field = bits [CNT_W-1:0], high field = bits [13+CNT_W-1:13]; unused bits ignored.
REQ-019 CR SHALL take effect the clk after capture; H1,H2,V1,V2,base,lineinc SHALL be programmed registers copied to active shadows only at en rising edge or at frame wrap (vcnt and hcnt wrap to 0).
REQ-020 Pixel tick asserted every pcnt+1 clks while en=1; pcnt=0 gives a tick every clk.
REQ-021 hcnt advances on tick, 0..hend then wraps to 0; on hcnt wrap vcnt advances 0..vend then wraps to 0.
REQ-022 hblank = (hcnt>=hsize); vblank = (vcnt>=vsize).
REQ-023 hsync raw = (hsync_start<=hcnt<hsync_end); output = raw XOR hpol; vsync likewise with vcnt, vpol.
REQ-024 All timing outputs SHALL be registered, one clk after counter state.
REQ-025 line_req SHALL pulse on the tick where hcnt becomes hsize, when next line (vcnt+1, or 0 on wrap) < vsize.
REQ-026 line_addr: accumulator loaded with base at frame wrap, increased by lineinc (mod 2^ADDR_W) after each line_req; line_addr for line n = base + n*lineinc.
REQ-027 frame_start pulses registered with hcnt==0&&vcnt==0 on a tick, including the first tick after enable.
REQ-028 en cleared: divider, hcnt, vcnt zeroed next clk; line_req, frame_start 0; hblank=vblank=1; hsync=hpol, vsync=vpol. Bus FSM keeps operating.
REQ-029 hend<hsize or hsync_end<=hsync_start: counters still wrap at hend; sync never active; no error flagged.

Reset
REQ-030 reset SHALL zero all programmed and shadow registers, counters, divider, accumulator; bus FSM to IDLE.
REQ-031 Output values during/after reset: cmdout=0, hsync=vsync=0, hblank=vblank=1, line_req=frame_start=0, line_addr=0.
REQ-032 reset mid-transaction SHALL abort the write with no register change and no response.

Verification
REQ-033 Write 0x00 then 32'h0000_0008 -> cmdout=3'b101 exactly one clk, two clks after request; frame_start on next clk tick.
REQ-034 hend=9,hsize=7,hsync 8..9,vend=4,vsize=3,pcnt=0,hpol=0 -> hblank high for hcnt 7..9, hsync high hcnt 8 only, line period 10 clks, frame 50 clks.
REQ-035 base=0x1000,lineinc=0x200,vsize=3 -> line_addr 0x1200,0x1400 with line_req, then 0x1000 before frame wrap; repeats each frame.
REQ-036 Rewrite H1 mid-frame while en=1 -> old hend in force until frame wrap, new hend from next frame.
REQ-037 pcnt=3 -> one tick every 4 clks; clearing en mid-line -> counters 0, blanks high next clk.
REQ-038 Assert reset during DATA state -> no cmdout response, target register unchanged, outputs at REQ-031 values.
